// File: rtl/qarb_pkg.sv
// Shared types and constants for the queue arbiter slice.
// Optional statistics outputs are enabled with the QARB_STATS_EN macro.
package qarb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SETTLE  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_A = 2'd0,
        REQ_B = 2'd1,
        REQ_D = 2'd2
    } req_id_t;

    localparam int unsigned NUM_REQ     = 3;
    localparam int unsigned QUEUE_DEPTH = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned STATE_W     = 2;
    localparam int unsigned STAT_W      = 8;

    // Next requester in A -> B -> D -> A order.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/queue_arbiter_rr.sv
// Three-way round-robin arbiter: combinational one-hot grant from a
// registered pointer that moves past the winner on each advance strobe.
module rr_arbiter3
    import qarb_pkg::*;
(
    input  logic               clock_10KHZ,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               advance,
    input  logic [ID_W-1:0]    winner,
    output logic [NUM_REQ-1:0] grant_c
);

    logic [ID_W-1:0] ptr;

    always_ff @(posedge clock_10KHZ or posedge reset) begin
        if (reset) begin
            ptr <= ID_W'(REQ_A);
        end else if (advance) begin
            ptr <= rr_next(winner);
        end
    end

    // Walk from the pointer and grant the first eligible requester.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        grant_c = '0;
        found   = 1'b0;
        idx     = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[idx]) begin
                grant_c[idx] = 1'b1;
                found        = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/queue_arbiter.sv
// Shares the 8-byte queue among producers A/B and consumer D, turning level
// req/ack handshakes into timed strobes. QARB_STATS_EN adds op counters and a stall flag.
module queue_arbiter
    import qarb_pkg::*;
#(
    parameter int unsigned OP_CYCLES  = 4,
    parameter int unsigned FULL_LEVEL = 7
) (
    input  logic              clock_10KHZ,
    input  logic              reset,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    input  logic              req_d,
    output logic              ack_d,
    output logic [DATA_W-1:0] deq_data,
    input  logic [LEN_W-1:0]  q_len,
    input  logic [DATA_W-1:0] q_data,
    output logic [DATA_W-1:0] q_data_in,
    output logic              q_enqueue,
    output logic              q_dequeue,
    output logic              busy
`ifdef QARB_STATS_EN
    ,
    output logic [STAT_W-1:0] enq_count,
    output logic [STAT_W-1:0] deq_count,
    output logic              stall_flag
`endif
);

    localparam int unsigned CNT_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE    = IDLE;
    localparam logic [STATE_W-1:0] S_ISSUE   = ISSUE;
    localparam logic [STATE_W-1:0] S_SETTLE  = SETTLE;
    localparam logic [STATE_W-1:0] S_RESPOND = RESPOND;

    logic [STATE_W-1:0] state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    win, win_nxt;
    logic [DATA_W-1:0]  data_in_nxt, deq_data_nxt;
    logic               enq_nxt, deq_nxt;
    logic               ack_a_nxt, ack_b_nxt, ack_d_nxt, busy_nxt;
    logic               room_c, has_data_c, advance_c;
    logic [NUM_REQ-1:0] eligible_c, grant_c;

    assign room_c     = q_len < LEN_W'(FULL_LEVEL);
    assign has_data_c = q_len != '0;
    assign eligible_c = {req_d & has_data_c, req_b & room_c, req_a & room_c};

    rr_arbiter3 u_arb (
        .clock_10KHZ (clock_10KHZ),
        .reset       (reset),
        .eligible    (eligible_c),
        .advance     (advance_c),
        .winner      (win),
        .grant_c     (grant_c)
    );

    // State and registered outputs.
    always_ff @(posedge clock_10KHZ or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            win       <= ID_W'(REQ_A);
            q_data_in <= '0;
            deq_data  <= '0;
            q_enqueue <= 1'b0;
            q_dequeue <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            ack_d     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            win       <= win_nxt;
            q_data_in <= data_in_nxt;
            deq_data  <= deq_data_nxt;
            q_enqueue <= enq_nxt;
            q_dequeue <= deq_nxt;
            ack_a     <= ack_a_nxt;
            ack_b     <= ack_b_nxt;
            ack_d     <= ack_d_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        win_nxt      = win;
        data_in_nxt  = q_data_in;
        deq_data_nxt = deq_data;
        enq_nxt      = 1'b0;
        deq_nxt      = 1'b0;
        ack_a_nxt    = 1'b0;
        ack_b_nxt    = 1'b0;
        ack_d_nxt    = 1'b0;
        advance_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (|grant_c) begin
                    state_nxt = S_ISSUE;
                    if (grant_c[REQ_A]) begin
                        win_nxt     = ID_W'(REQ_A);
                        data_in_nxt = data_a;
                    end else if (grant_c[REQ_B]) begin
                        win_nxt     = ID_W'(REQ_B);
                        data_in_nxt = data_b;
                    end else begin
                        win_nxt = ID_W'(REQ_D);
                    end
                    enq_nxt = ~grant_c[REQ_D];
                    deq_nxt = grant_c[REQ_D];
                end
            end
            S_ISSUE: begin
                state_nxt = S_SETTLE;
                cnt_nxt   = '0;
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(OP_CYCLES - 1)) begin
                    state_nxt = S_RESPOND;
                    cnt_nxt   = '0;
                    ack_a_nxt = (win == REQ_A);
                    ack_b_nxt = (win == REQ_B);
                    ack_d_nxt = (win == REQ_D);
                    if (win == REQ_D) begin
                        deq_data_nxt = q_data;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RESPOND: begin
                state_nxt = S_IDLE;
                advance_c = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

`ifdef QARB_STATS_EN
    localparam int unsigned STALL_W = 4;

    logic [STALL_W-1:0] stall_run;
    logic               inelig_c;

    assign inelig_c = ((req_a | req_b) & ~room_c) | (req_d & ~has_data_c);

    // Completed-op counters and a sticky flag for requests starved 16 IDLE cycles.
    always_ff @(posedge clock_10KHZ or posedge reset) begin
        if (reset) begin
            enq_count  <= '0;
            deq_count  <= '0;
            stall_run  <= '0;
            stall_flag <= 1'b0;
        end else begin
            if (state == S_RESPOND) begin
                if (win == REQ_D) begin
                    deq_count <= deq_count + STAT_W'(1);
                end else begin
                    enq_count <= enq_count + STAT_W'(1);
                end
            end
            if ((state == S_IDLE) && inelig_c) begin
                if (stall_run == '1) begin
                    stall_flag <= 1'b1;
                end else begin
                    stall_run <= stall_run + STALL_W'(1);
                end
            end else begin
                stall_run <= '0;
            end
        end
    end
`endif

endmodule

// File: doc/queue_arbiter.md
Name: queue_arbiter

Overview:
- Sequences the 8-byte `queue` block and shares it among three requesters: producer A, producer B, and consumer D.
- Converts level req/ack handshakes into the single-cycle enqueue/dequeue strobes the queue expects.
- Holds the queue's inputs stable for a fixed settle window after each strobe.
- Sits between the producer/consumer logic and the queue in the clock_10KHZ domain.

Parameters:
- OP_CYCLES, 4, settle cycles after each strobe before the op is treated as complete (range 1..15).
- FULL_LEVEL, 7, q_len value at or above which enqueues are withheld (the queue never reports more than 7).

Ports:
- clock_10KHZ  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_a  in  1  producer A enqueue request (level)
- data_a  in  8  producer A byte; stable while req_a is high
- ack_a  out  1  one-cycle pulse: A's byte was enqueued
- req_b  in  1  producer B enqueue request (level)
- data_b  in  8  producer B byte; stable while req_b is high
- ack_b  out  1  one-cycle pulse: B's byte was enqueued
- req_d  in  1  consumer dequeue request (level)
- ack_d  out  1  one-cycle pulse: deq_data is valid
- deq_data  out  8  dequeued byte, held until the next dequeue
- q_len  in  4  queue occupancy (len_out)
- q_data  in  8  queue data_out
- q_data_in  out  8  byte presented to the queue
- q_enqueue  out  1  enqueue strobe
- q_dequeue  out  1  dequeue strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking: reset is asynchronous and active-high; the clock is clock_10KHZ. All outputs are registered.
- Reset values: all outputs 0, state IDLE, round-robin pointer set to A, settle counter 0.
- States:
  - IDLE → ISSUE when at least one eligible request exists.
  - ISSUE → SETTLE after 1 cycle.
  - SETTLE → RESPOND when the counter reaches OP_CYCLES-1.
  - RESPOND → IDLE after 1 cycle.
- Eligibility, sampled in IDLE:
  - req_a/req_b are eligible only if q_len < FULL_LEVEL.
  - req_d is eligible only if q_len != 0.
  - Ineligible requests stay pending with no ack; there is no error.
- Arbitration:
  - Round-robin over the order A → B → D, starting from the pointer.
  - The first eligible requester wins.
  - In RESPOND the pointer moves to winner+1 (mod 3).
- IDLE win: the winner index and the winning byte (data_a or data_b) are latched; q_data_in is driven from the latch.
- ISSUE: q_enqueue=1 (A/B win) or q_dequeue=1 (D win) for exactly 1 cycle.
- SETTLE: both strobes are 0. q_data_in holds the latched value. The counter increments.
- RESPOND:
  - The winner's ack is high for 1 cycle.
  - On a D win, deq_data <= q_data in the same cycle.
  - Return to IDLE.
- Requester contract: deassert req on the edge that ends the ack cycle. IDLE therefore sees req low and does not re-grant.
- Latency: req sampled high in IDLE at edge k → strobe during cycle k+1 → ack during cycle k+2+OP_CYCLES (6 cycles with the default).
- Requests arriving in non-IDLE states wait; they are never lost while held high.
- Simultaneous requests are resolved by the pointer only. There is no fixed priority.
- At most one strobe is active at any time, and q_enqueue and q_dequeue are never high together.
- Reset mid-operation: aborts immediately. No ack is issued; the aborted requester must re-request. The queue shares the same reset.

Optional Feature:
- Macro: QARB_STATS_EN.
- With the macro defined:
  - Output ports enq_count[7:0] and deq_count[7:0] are added, each reset to 0.
  - enq_count increments in RESPOND on an A/B win; deq_count increments in RESPOND on a D win.
  - Both counters wrap at 255→0.
  - A stall_flag output (reset 0) is set when any request is held ineligible for 16 consecutive IDLE cycles, and cleared by reset only.
- Without the macro: none of these ports or registers exist, and all other behaviour is identical.

Decomposition:
- Package qarb_pkg:
  - state_t enum (IDLE, ISSUE, SETTLE, RESPOND).
  - req_id_t enum (REQ_A=0, REQ_B=1, REQ_D=2).
  - Constants NUM_REQ=3 and QUEUE_DEPTH=8.
- Sub-module rr_arbiter3:
  - 3-bit eligible vector in; one-hot grant out.
  - Registered pointer, updated on an advance strobe from RESPOND.
  - Instantiated once.

Test Plan:
- Reset, then req_a=1 with data_a=8'h3C, q_len=0 → q_enqueue high 1 cycle, q_data_in=8'h3C through SETTLE, ack_a pulses 6 cycles after sampling, busy falls the cycle after.
- req_a, req_b, req_d all held high, q_len=3 → grants in order A, B, D, A; no strobe overlap; each ack is exactly 1 cycle.
- q_len=7, req_b=1 → no q_enqueue and no ack_b; drop q_len to 6 → grant follows within 1 cycle of IDLE sampling.
- q_len=0, req_d=1 → no q_dequeue. Then enqueue 8'hA5 via producer A and run the real queue → ack_d with deq_data=8'hA5.
- Assert reset during SETTLE → all outputs 0 immediately, no ack, pointer at A; re-request completes normally.
- With QARB_STATS_EN: 300 enqueue/dequeue pairs → enq_count=deq_count=8'd44 (wrapped). Hold req_a with q_len=7 for 16 IDLE cycles → stall_flag=1.
